ordered_set_tx_scheduler: RTL
=============================

// Module: ordered_set_tx_scheduler
// PURPOSE
//  Transmit-side scheduler for the PCIe PHY logical layer. Arbitrates the lane
//  TX path between LTSSM ordered-set requests (TS1/TS2/EIEOS/EIOS), periodic
//  SKP insertion, and the TLP/DLLP data stream. Commands the ordered-set
//  generator one OS at a time and never splits a data packet.
// PARAMETERS
//  SKP_INTERVAL  1180  clk cycles between SKP schedules (rate-independent count)
//  SKP_MAX_PEND  3     max queued SKPs; further intervals are dropped
//  TS_PER_EIEOS  32    TS OSes between forced EIEOS at gen3+
// PORTS
//  clk_i             in   1   clock
//  rst_n_i           in   1   synchronous reset, active low
//  curr_data_rate_i  in   rate_speed_e  current link rate
//  skp_en_i          in   1   enable SKP scheduling
//  ts_req_i          in   1   level: LTSSM wants TS sent
//  ts_type_i         in   1   0=TS1, 1=TS2; sampled at os_start_o
//  eieos_req_i       in   1   level: EIEOS wanted
//  eios_req_i        in   1   level: enter electrical idle
//  data_valid_i      in   1   data stream beat valid
//  data_last_i       in   1   last beat of packet
//  data_ready_o      out  1   data beat accepted
//  os_start_o        out  1   1-cycle pulse: generator begins os_type_o
//  os_type_o         out  os_type_e  OS in progress; stable until os_done_i
//  os_done_i         in   1   generator finished the current OS
//  tx_sel_o          out  2   0=none, 1=data, 2=ordered set
//  ts_sent_o         out  1   pulse on os_done_i of a TS1/TS2
//  elec_idle_o       out  1   high in ST_ELEC_IDLE
// BEHAVIOUR
//  Reset: state ST_IDLE; all outputs 0; os_type_o=OS_TS1; all counters 0.
//  States: ST_IDLE, ST_OS_START, ST_OS_WAIT, ST_DATA, ST_ELEC_IDLE.
//  ST_IDLE arbitration, fixed priority: eios_req > eieos_req or forced EIEOS >
//   skp_pend>0 > ts_req > data_valid. Winner OS: latch type, go ST_OS_START.
//   Data: go ST_DATA. Nothing: stay, tx_sel_o=0.
//  ST_OS_START: os_start_o=1 for exactly one cycle, tx_sel_o=2 -> ST_OS_WAIT.
//  ST_OS_WAIT: hold type; on os_done_i: EIOS -> ST_ELEC_IDLE, else ST_IDLE.
//   A new os_start_o therefore occurs no sooner than 2 cycles after os_done_i.
//   os_done_i outside ST_OS_WAIT is ignored.
//  ST_DATA: data_ready_o=1, tx_sel_o=1; on valid&last -> ST_IDLE. Packets
//   are never preempted: pending SKP/TS/EIOS wait for the last beat.
//  ST_ELEC_IDLE: elec_idle_o=1, tx_sel_o=0; exit to ST_IDLE when !eios_req_i.
//  SKP timer: counts cycles while skp_en_i & state!=ST_ELEC_IDLE; at
//   SKP_INTERVAL-1 wraps to 0 and increments skp_pend (saturate SKP_MAX_PEND).
//   skp_pend decrements when an SKP os_start_o issues; simultaneous wrap and
//   issue leaves skp_pend unchanged. skp_en_i=0 clears timer and skp_pend.
//  Forced EIEOS: only when curr_data_rate_i>=gen3. ts_cnt increments at each
//   TS os_start_o; when ts_cnt==TS_PER_EIEOS, force EIEOS before the next TS.
//   Any EIEOS issue clears ts_cnt. Below gen3 ts_cnt held at 0.
//  Rate change (curr_data_rate_i differs from last cycle): clear SKP timer,
//   skp_pend, ts_cnt; an OS in flight completes normally.
//  Reset mid-operation: immediate return to reset state, no os_done wait.
// STRUCTURE
//  pcie_phy_pkg gains: os_type_e {OS_TS1,OS_TS2,OS_SKP,OS_EIEOS,OS_EIOS};
//   tx_sel_e {TX_NONE,TX_DATA,TX_OS}. rate_speed_e reused.
//  Sub-module skp_interval_timer (counter + saturating pending count,
//   inc/dec/clear ports); arbiter and FSM stay in this module.
// TESTING
//  1 ts_req=1,type=0 at gen1, done after 4 cycles -> os_start pulses with
//    OS_TS1 every 6 cycles, ts_sent_o each done, no EIEOS ever.
//  2 Same at gen3 -> after 32 TS starts, 33rd start is OS_EIEOS, then TS resumes.
//  3 SKP_INTERVAL=16, 40-beat packet streaming -> no OS during packet; after
//    last beat 2 SKPs issued back to back before next TS; pend never >3.
//  4 eios_req during data packet -> EIOS starts after last beat; elec_idle_o=1
//    after done; SKP timer frozen; drop eios_req -> ST_IDLE next cycle.
//  5 eieos_req and ts_req and skp_pend simultaneously -> order EIEOS,SKP,TS.
//  6 rst_n_i low mid ST_OS_WAIT -> next cycle all outputs 0, counters 0.

Source files
------------

// File: rtl/ordered_set_tx_scheduler_pkg.sv
// Shared types for the PHY logical-layer transmit scheduler: link rates,
// ordered-set kinds, lane TX source select and the scheduler state encoding.
package ordered_set_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    RATE_GEN1,
    RATE_GEN2,
    RATE_GEN3,
    RATE_GEN4,
    RATE_GEN5
  } rate_speed_e;

  typedef enum logic [2:0] {
    OS_TS1,
    OS_TS2,
    OS_SKP,
    OS_EIEOS,
    OS_EIOS
  } os_type_e;

  typedef enum logic [1:0] {
    TX_NONE,
    TX_DATA,
    TX_OS
  } tx_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OS_START,
    ST_OS_WAIT,
    ST_DATA,
    ST_ELEC_IDLE
  } sched_state_e;

  localparam int unsigned SKP_INTERVAL_DEFAULT = 1180;
  localparam int unsigned SKP_MAX_PEND_DEFAULT = 3;
  localparam int unsigned TS_PER_EIEOS_DEFAULT = 32;

  // TS1 and TS2 are treated alike for counting and for the sent pulse
  function automatic logic is_ts(os_type_e t);
    return (t == OS_TS1) || (t == OS_TS2);
  endfunction

endpackage

// File: rtl/ordered_set_tx_scheduler_if.sv
// Handshake bundle between the scheduler, the data stream source and the
// ordered-set generator. The scheduler side is the master.
interface ordered_set_tx_scheduler_if;
  import ordered_set_tx_scheduler_pkg::*;

  logic     data_valid;
  logic     data_last;
  logic     data_ready;
  logic     os_start;
  os_type_e os_type;
  logic     os_done;
  tx_sel_e  tx_sel;

  modport master (
    input  data_valid, data_last, os_done,
    output data_ready, os_start, os_type, tx_sel
  );

  modport slave (
    output data_valid, data_last, os_done,
    input  data_ready, os_start, os_type, tx_sel
  );

endinterface

// File: rtl/ordered_set_tx_scheduler_skp_timer.sv
// SKP interval timer: free-running cycle counter that wraps every INTERVAL
// cycles and banks each wrap as a pending SKP, saturating at MAX_PEND.
module skp_interval_timer #(
  parameter int unsigned INTERVAL = 1180,
  parameter int unsigned MAX_PEND = 3,
  localparam int CNT_W  = (INTERVAL > 1) ? $clog2(INTERVAL) : 1,
  localparam int PEND_W = $clog2(MAX_PEND + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              run,
  input  logic              clear,
  input  logic              dec,
  output logic [PEND_W-1:0] pend
);

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = run && (cnt == CNT_W'(INTERVAL - 1));

  // Count while running; a wrap and an issue in the same cycle cancel out
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clear) begin
      cnt  <= '0;
      pend <= '0;
    end else begin
      if (run) begin
        cnt <= wrap ? '0 : cnt + CNT_W'(1);
      end
      if (wrap && !dec) begin
        if (pend != PEND_W'(MAX_PEND)) begin
          pend <= pend + PEND_W'(1);
        end
      end else if (dec && !wrap && (pend != '0)) begin
        pend <= pend - PEND_W'(1);
      end
    end
  end

endmodule

// File: rtl/ordered_set_tx_scheduler.sv
// Lane TX scheduler: arbitrates between LTSSM ordered-set requests, periodic
// SKP insertion and the packet stream, one ordered set at a time, and never
// cuts a packet short.
module ordered_set_tx_scheduler
  import ordered_set_tx_scheduler_pkg::*;
#(
  parameter int unsigned SKP_INTERVAL = SKP_INTERVAL_DEFAULT,
  parameter int unsigned SKP_MAX_PEND = SKP_MAX_PEND_DEFAULT,
  parameter int unsigned TS_PER_EIEOS = TS_PER_EIEOS_DEFAULT
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  rate_speed_e                       curr_data_rate_i,
  input  logic                              skp_en_i,
  input  logic                              ts_req_i,
  input  logic                              ts_type_i,
  input  logic                              eieos_req_i,
  input  logic                              eios_req_i,
  ordered_set_tx_scheduler_if.master        bus,
  output logic                              ts_sent_o,
  output logic                              elec_idle_o
);

  localparam int PEND_W = $clog2(SKP_MAX_PEND + 1);
  localparam int TS_W   = $clog2(TS_PER_EIEOS + 1);

  sched_state_e      state;
  rate_speed_e       rate_q;
  logic              rate_chg;
  logic              gen3_plus;
  logic [TS_W-1:0]   ts_cnt;
  logic              force_eieos;
  logic [PEND_W-1:0] skp_pend;
  logic              skp_run;
  logic              skp_clear;
  logic              skp_issue;
  logic              arb_valid;
  os_type_e          arb_type;

  assign rate_chg    = (curr_data_rate_i != rate_q);
  assign gen3_plus   = (curr_data_rate_i >= RATE_GEN3);
  assign force_eieos = gen3_plus && ts_req_i && (ts_cnt == TS_W'(TS_PER_EIEOS));
  assign skp_run     = skp_en_i && (state != ST_ELEC_IDLE);
  assign skp_clear   = !skp_en_i || rate_chg;
  assign skp_issue   = (state == ST_OS_START) && (bus.os_type == OS_SKP);

  skp_interval_timer #(
    .INTERVAL (SKP_INTERVAL),
    .MAX_PEND (SKP_MAX_PEND)
  ) u_skp_timer (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .run     (skp_run),
    .clear   (skp_clear),
    .dec     (skp_issue),
    .pend    (skp_pend)
  );

  // Remember last cycle's rate so a rate switch can flush the schedulers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rate_q <= RATE_GEN1;
    end else begin
      rate_q <= curr_data_rate_i;
    end
  end

  // Count TS starts toward the next forced EIEOS; only meaningful at gen3+
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || rate_chg || !gen3_plus) begin
      ts_cnt <= '0;
    end else if (state == ST_OS_START) begin
      if (bus.os_type == OS_EIEOS) begin
        ts_cnt <= '0;
      end else if (is_ts(bus.os_type) && (ts_cnt != TS_W'(TS_PER_EIEOS))) begin
        ts_cnt <= ts_cnt + TS_W'(1);
      end
    end
  end

  // Fixed-priority pick of the next ordered set to send from idle
  always_comb begin
    arb_valid = 1'b1;
    arb_type  = OS_TS1;
    if (eios_req_i) begin
      arb_type = OS_EIOS;
    end else if (eieos_req_i || force_eieos) begin
      arb_type = OS_EIEOS;
    end else if (skp_pend != '0) begin
      arb_type = OS_SKP;
    end else if (ts_req_i) begin
      arb_type = ts_type_i ? OS_TS2 : OS_TS1;
    end else begin
      arb_valid = 1'b0;
    end
  end

  // Scheduler FSM; every output is registered alongside the state it reflects
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state          <= ST_IDLE;
      bus.os_start   <= 1'b0;
      bus.os_type    <= OS_TS1;
      bus.tx_sel     <= TX_NONE;
      bus.data_ready <= 1'b0;
      ts_sent_o      <= 1'b0;
      elec_idle_o    <= 1'b0;
    end else begin
      bus.os_start <= 1'b0;
      ts_sent_o    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            state        <= ST_OS_START;
            bus.os_start <= 1'b1;
            bus.os_type  <= arb_type;
            bus.tx_sel   <= TX_OS;
          end else if (bus.data_valid) begin
            state          <= ST_DATA;
            bus.data_ready <= 1'b1;
            bus.tx_sel     <= TX_DATA;
          end else begin
            bus.tx_sel <= TX_NONE;
          end
        end
        ST_OS_START: begin
          state <= ST_OS_WAIT;
        end
        ST_OS_WAIT: begin
          if (bus.os_done) begin
            bus.tx_sel <= TX_NONE;
            ts_sent_o  <= is_ts(bus.os_type);
            if (bus.os_type == OS_EIOS) begin
              state       <= ST_ELEC_IDLE;
              elec_idle_o <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (bus.data_valid && bus.data_last) begin
            state          <= ST_IDLE;
            bus.data_ready <= 1'b0;
            bus.tx_sel     <= TX_NONE;
          end
        end
        ST_ELEC_IDLE: begin
          if (!eios_req_i) begin
            state       <= ST_IDLE;
            elec_idle_o <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
